// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store channel.
// Writes commit at the accepting edge. Reads are sampled at the accepting
// edge, travel a LATENCY-deep pipeline and queue in an in-order response
// FIFO. A credit counter caps outstanding reads so the FIFO never overflows.
module dmem_responder #(
    parameter int IDX_W     = 13,
    parameter int LATENCY   = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        busy
);

    localparam int WORDS = 1 << IDX_W;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    logic [15:0]      mem [WORDS];
    logic [IDX_W-1:0] idx;
    logic             fire;
    logic             rd_fire;
    logic             wr_fire;
    logic             push;
    logic             pop;
    logic [CNT_W-1:0] credit;

    // Read pipeline: one valid tag and one data word per stage.
    logic             pipe_vld  [LATENCY];
    logic [15:0]      pipe_data [LATENCY];

    // Response FIFO.
    logic [15:0]      fifo_mem [RSP_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic [15:0]      last_data;

    // Byte-address bit 0 and bits above the word index are deliberately ignored.
    logic             unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[15:IDX_W+1], req_addr[0]};

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign idx       = req_addr[IDX_W:1];
    assign req_ready = (credit < CNT_W'(RSP_DEPTH));
    assign fire      = req_valid & req_ready;
    assign rd_fire   = fire & ~req_wr;
    assign wr_fire   = fire & req_wr;
    assign push      = pipe_vld[LATENCY-1];
    assign rsp_valid = (fifo_cnt != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign rsp_data  = rsp_valid ? fifo_mem[rd_ptr] : last_data;
    assign busy      = (credit != '0);

    // Storage array and read-data path: written and sampled at the accepting edge.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[idx] <= req_wdata;
        end
        pipe_data[0] <= mem[idx];
        for (int i = 1; i < LATENCY; i++) begin
            pipe_data[i] <= pipe_data[i-1];
        end
        if (push) begin
            fifo_mem[wr_ptr] <= pipe_data[LATENCY-1];
        end
    end

    // Read-valid tags shift toward the response FIFO; reset drops in-flight reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                pipe_vld[i] <= 1'b0;
            end
        end else begin
            pipe_vld[0] <= rd_fire;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    // Outstanding-read credits: +1 per accepted read, -1 per popped response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit <= '0;
        end else if (rd_fire && !pop) begin
            credit <= credit + CNT_W'(1);
        end else if (!rd_fire && pop) begin
            credit <= credit - CNT_W'(1);
        end
    end

    // Response FIFO pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (push && !pop) begin
                fifo_cnt <= fifo_cnt + CNT_W'(1);
            end else if (!push && pop) begin
                fifo_cnt <= fifo_cnt - CNT_W'(1);
            end
        end
    end

    // Holds the most recently popped word so rsp_data stays put while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_data <= '0;
        end else if (pop) begin
            last_data <= fifo_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with an in-order response scoreboard.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    dmem_responder #(.IDX_W(13), .LATENCY(4), .RSP_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every response the DUT hands over is compared to the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
            end else if (rsp_ready === 1'b1) begin
                check("rsp_data", {16'd0, rsp_data}, {16'd0, exp_q[0]});
                exp_q.delete(0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        @(negedge clk);
        check("wr_ready", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
    endtask

    task automatic issue_read(input logic [15:0] addr, input logic [15:0] exp, output logic acc);
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = addr;
        @(negedge clk);
        acc = req_ready;
        if (acc) exp_q.push_back(exp);
        step();
        req_valid = 1'b0;
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", exp_q.size(), 32'd0);
        step();
    endtask

    initial begin
        logic acc;
        int   n_acc;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;

        // 1. Reset then idle
        @(negedge clk);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_req_ready", {31'd0, req_ready}, 32'd1);
        check("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_rsp_data", {16'd0, rsp_data}, 32'd0);
        step();

        // 2. Write then read: latency and busy window
        do_write(16'h0010, 16'hBEEF);
        issue_read(16'h0010, 16'hBEEF, acc);
        check("t2_accept", {31'd0, acc}, 32'd1);
        for (int j = 0; j <= 4; j++) begin
            @(negedge clk);
            check("t2_rsp_valid", {31'd0, rsp_valid}, (j == 4) ? 32'd1 : 32'd0);
            check("t2_busy", {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        check("t2_busy_after", {31'd0, busy}, 32'd0);
        check("t2_valid_after", {31'd0, rsp_valid}, 32'd0);
        check("t2_data_hold", {16'd0, rsp_data}, 32'h0000BEEF);
        step();

        // 3. Back-to-back reads with odd address
        do_write(16'h0020, 16'h1111);
        do_write(16'h0022, 16'h2222);
        issue_read(16'h0021, 16'h1111, acc);
        check("t3_accept0", {31'd0, acc}, 32'd1);
        issue_read(16'h0022, 16'h2222, acc);
        check("t3_accept1", {31'd0, acc}, 32'd1);
        for (int i = 0; i < 20 && rsp_valid !== 1'b1; i++) @(negedge clk);
        check("t3_first_valid", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        check("t3_second_valid", {31'd0, rsp_valid}, 32'd1);
        @(negedge clk);
        check("t3_done_valid", {31'd0, rsp_valid}, 32'd0);
        step();

        // 4. Read-then-write hazard
        do_write(16'h0030, 16'h0005);
        issue_read(16'h0030, 16'h0005, acc);
        do_write(16'h0030, 16'h0009);
        issue_read(16'h0030, 16'h0009, acc);
        drain(20);

        // 5. Backpressure and credits
        for (int i = 0; i < 6; i++) do_write(16'h0040 + 16'(2 * i), 16'hA000 + 16'(i));
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            issue_read(16'h0040 + 16'(2 * i), 16'hA000 + 16'(i), acc);
            if (acc) n_acc++;
        end
        check("t5_accepted", n_acc, 32'd4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_hold_ready", {31'd0, req_ready}, 32'd0);
            check("t5_hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("t5_hold_data", {16'd0, rsp_data}, 32'h0000A000);
        end
        step();
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_pop_valid", {31'd0, rsp_valid}, (i < 4) ? 32'd1 : 32'd0);
            if (i == 0) check("t5_ready_before_pop", {31'd0, req_ready}, 32'd0);
            if (i == 1) check("t5_ready_after_pop", {31'd0, req_ready}, 32'd1);
        end
        check("t5_queue_empty", exp_q.size(), 32'd0);
        step();

        // 6. Reset with reads in flight
        do_write(16'h0050, 16'h5A5A);
        for (int i = 0; i < 3; i++) issue_read(16'h0040 + 16'(2 * i), 16'hA000 + 16'(i), acc);
        step();
        step();
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("t6_async_valid", {31'd0, rsp_valid}, 32'd0);
        check("t6_async_busy", {31'd0, busy}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t6_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_req_ready", {31'd0, req_ready}, 32'd1);
        step();
        issue_read(16'h0050, 16'h5A5A, acc);
        check("t6_accept", {31'd0, acc}, 32'd1);
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
